ysyx_25060173_idu_issue: RTL and testbench

Decode-and-issue stage directly upstream of the ALU. It accepts fetched instructions over a valid/ready handshake and decodes ADDI, AUIPC and EBREAK. It reads rs1 from the register file and buffers fully formed ALU operand bundles (alu_src1, alu_src2, alu_op, rd, rd_wen, flags) in a small skid FIFO. The EXU consumes one bundle per handshake; the ALU plus register-file writeback complete on the clock edge of that handshake.

---
 rtl/ysyx_25060173_pkg.sv | 28 ++
 rtl/ysyx_25060173_idu_decode.sv | 33 +++
 rtl/ysyx_25060173_idu_issue.sv | 110 +++++++++++
 tb/tb_ysyx_25060173_idu_issue.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25060173_pkg.sv
// Shared decode constants and the ALU issue bundle for the IDU issue stage.
package ysyx_25060173_pkg;

  localparam int          XLEN        = 32;
  localparam logic [6:0]  OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0]  OPC_AUIPC   = 7'b0010111;
  localparam logic [31:0] EBREAK_INST = 32'h00100073;

  localparam logic [1:0] ALU_OP_NONE  = 2'b00;
  localparam logic [1:0] ALU_OP_ADDI  = 2'b01;
  localparam logic [1:0] ALU_OP_AUIPC = 2'b10;

  typedef struct packed {
    logic [31:0] src1;
    logic [31:0] src2;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        rd_wen;
    logic [31:0] pc;
    logic        ebreak;
    logic        illegal;
  } issue_t;

  function automatic logic is_addi(input logic [31:0] inst);
    return (inst[6:0] == OPC_OPIMM) && (inst[14:12] == 3'b000);
  endfunction

endpackage

// File: rtl/ysyx_25060173_idu_decode.sv
// Combinational decode of ADDI / AUIPC / EBREAK into a fully formed ALU issue bundle.
module ysyx_25060173_idu_decode
  import ysyx_25060173_pkg::*;
(
  input  logic [31:0] inst_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] rs1_data_i,
  output issue_t      bundle_o
);

  always_comb begin
    bundle_o    = '0;
    bundle_o.pc = pc_i;
    if (is_addi(inst_i)) begin
      bundle_o.op     = ALU_OP_ADDI;
      bundle_o.src1   = rs1_data_i;
      bundle_o.src2   = {{20{inst_i[31]}}, inst_i[31:20]};
      bundle_o.rd     = inst_i[11:7];
      bundle_o.rd_wen = |inst_i[11:7];
    end else if (inst_i[6:0] == OPC_AUIPC) begin
      bundle_o.op     = ALU_OP_AUIPC;
      bundle_o.src1   = pc_i;
      bundle_o.src2   = {inst_i[31:12], 12'b0};
      bundle_o.rd     = inst_i[11:7];
      bundle_o.rd_wen = |inst_i[11:7];
    end else if (inst_i == EBREAK_INST) begin
      bundle_o.ebreak = 1'b1;
    end else begin
      bundle_o.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_25060173_idu_issue.sv
// Decode-and-issue stage: decodes on accept and buffers ALU bundles in a small skid FIFO
// with a RAW interlock against buffered, not-yet-written destinations.
module ysyx_25060173_idu_issue
  import ysyx_25060173_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [31:0]     in_inst,
  output logic [4:0]      rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_src1,
  output logic [XLEN-1:0] alu_src2,
  output logic [1:0]      alu_op,
  output logic [4:0]      out_rd,
  output logic            out_rd_wen,
  output logic [XLEN-1:0] out_pc,
  output logic            out_ebreak,
  output logic            out_illegal
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  issue_t              mem_q [DEPTH];
  logic [DEPTH-1:0]    vld_q, vld_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  issue_t              dec, head;
  logic                hit, hazard, push, pop;

  assign rf_raddr = in_inst[19:15];

  ysyx_25060173_idu_decode u_decode (
    .inst_i     (in_inst),
    .pc_i       (in_pc),
    .rs1_data_i (rf_rdata),
    .bundle_o   (dec)
  );

  // Interlock only uses registered entries, so a popping producer releases the
  // consumer one edge later, after its writeback has landed in the register file.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (vld_q[i] && mem_q[i].rd_wen && (mem_q[i].rd == in_inst[19:15])) hit = 1'b1;
  end

  assign hazard    = hit & is_addi(in_inst);
  assign out_valid = (cnt_q != '0);
  assign in_ready  = (cnt_q < FULL_CNT) & ~hazard & ~flush;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (pop)  vld_d[rd_ptr_q] = 1'b0;
    if (push) vld_d[wr_ptr_q] = 1'b1;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
      vld_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      vld_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      if (push) mem_q[wr_ptr_q] <= dec;
    end
  end

  assign head        = mem_q[rd_ptr_q];
  assign alu_src1    = head.src1;
  assign alu_src2    = head.src2;
  assign alu_op      = head.op;
  assign out_rd      = head.rd;
  assign out_rd_wen  = head.rd_wen;
  assign out_pc      = head.pc;
  assign out_ebreak  = head.ebreak;
  assign out_illegal = head.illegal;

endmodule

// File: tb/tb_ysyx_25060173_idu_issue.sv
// Directed bench for the IDU issue stage; the bench owns a register-file/EXU model.
module tb_ysyx_25060173_idu_issue;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_inst, rf_rdata, alu_src1, alu_src2, out_pc;
  logic [4:0]  rf_raddr, out_rd;
  logic [1:0]  alu_op;
  logic        out_rd_wen, out_ebreak, out_illegal;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  ysyx_25060173_idu_issue #(.XLEN(32), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
    .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_op(alu_op),
    .out_rd(out_rd), .out_rd_wen(out_rd_wen), .out_pc(out_pc),
    .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  // Register file + EXU model: writeback commits on the pop edge.
  logic [31:0] rf [32];
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  always @(posedge clk) begin
    if (rf_we) rf[rf_wa] <= rf_wd;
    else if (out_valid && out_ready && !flush && out_rd_wen && out_rd != 5'd0)
      rf[out_rd] <= alu_src1 + alu_src2;
  end
  assign rf_rdata = (rf_raddr == 5'd0) ? 32'd0 : rf[rf_raddr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic rf_set(input logic [4:0] a, input logic [31:0] d);
    rf_we = 1'b1; rf_wa = a; rf_wd = d;
    @(negedge clk);
    rf_we = 1'b0;
  endtask

  task automatic push(input logic [31:0] inst, input logic [31:0] pc);
    in_valid = 1'b1; in_inst = inst; in_pc = pc;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  typedef struct {
    logic [31:0] inst, pc, src1, src2;
    logic [1:0]  op;
    logic [4:0]  rd;
    logic        wen, ebreak, illegal;
  } vec_t;

  vec_t vecs [7];

  initial begin
    vecs[0] = '{32'h00500093, 32'h00000000, 32'h00000000, 32'h00000005, 2'b01, 5'd1, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{32'h12345117, 32'h80000000, 32'h80000000, 32'h12345000, 2'b10, 5'd2, 1'b1, 1'b0, 1'b0};
    vecs[2] = '{32'h00000000, 32'h00000004, 32'h00000000, 32'h00000000, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[3] = '{32'h00100073, 32'h00000008, 32'h00000000, 32'h00000000, 2'b00, 5'd0, 1'b0, 1'b1, 1'b0};
    vecs[4] = '{32'h80028013, 32'h0000000c, 32'h00000100, 32'hfffff800, 2'b01, 5'd0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{32'h00001093, 32'h00000010, 32'h00000000, 32'h00000000, 2'b00, 5'd0, 1'b0, 1'b0, 1'b1};
    vecs[6] = '{32'hfffff017, 32'h00000014, 32'h00000014, 32'hfffff000, 2'b10, 5'd0, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_pc = 32'h0; rf_we = 1'b0; rf_wa = 5'd0; rf_wd = 32'h0;
    @(negedge clk); @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_src1", alu_src1, 32'd0);
    rst = 1'b0;
    rf_set(5'd5, 32'h100);

    // Table: push one bundle, check it next cycle, then pop it.
    for (int i = 0; i < 7; i++) begin
      logic [31:0] ins;
      ins = vecs[i].inst;
      in_valid = 1'b1; in_inst = ins; in_pc = vecs[i].pc;
      #1;
      chk($sformatf("v%0d_in_ready", i), 32'(in_ready), 32'd1);
      chk($sformatf("v%0d_rf_raddr", i), 32'(rf_raddr), 32'(ins[19:15]));
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      chk($sformatf("v%0d_out_valid", i), 32'(out_valid), 32'd1);
      chk($sformatf("v%0d_src1", i), alu_src1, vecs[i].src1);
      chk($sformatf("v%0d_src2", i), alu_src2, vecs[i].src2);
      chk($sformatf("v%0d_op", i), 32'(alu_op), 32'(vecs[i].op));
      chk($sformatf("v%0d_rd", i), 32'(out_rd), 32'(vecs[i].rd));
      chk($sformatf("v%0d_wen", i), 32'(out_rd_wen), 32'(vecs[i].wen));
      chk($sformatf("v%0d_ebreak", i), 32'(out_ebreak), 32'(vecs[i].ebreak));
      chk($sformatf("v%0d_illegal", i), 32'(out_illegal), 32'(vecs[i].illegal));
      chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      #1;
      chk($sformatf("v%0d_drained", i), 32'(out_valid), 32'd0);
    end

    // RAW hazard on x1.
    @(negedge clk);
    rf_set(5'd1, 32'd0);
    push(32'h00500093, 32'h200);
    in_valid = 1'b1; in_inst = 32'hfff08193; in_pc = 32'h204;
    #1 chk("haz_blocked0", 32'(in_ready), 32'd0);
    @(negedge clk);
    #1 chk("haz_blocked1", 32'(in_ready), 32'd0);
    out_ready = 1'b1;
    #1 chk("haz_blocked_popcycle", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("haz_released", 32'(in_ready), 32'd1);
    chk("haz_rf_x1", rf_rdata, 32'd5);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("haz_out_valid", 32'(out_valid), 32'd1);
    chk("haz_src1", alu_src1, 32'd5);
    chk("haz_src2", alu_src2, 32'hffffffff);
    chk("haz_rd", 32'(out_rd), 32'd3);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Full + backpressure, order preserved.
    push(32'h00001317, 32'h100);
    push(32'h00002397, 32'h104);
    in_valid = 1'b1; in_inst = 32'h00003417; in_pc = 32'h108;
    #1;
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_head_pc", out_pc, 32'h100);
    out_ready = 1'b1;
    #1 chk("full_no_passthru", 32'(in_ready), 32'd0);
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("full_ready_after_pop", 32'(in_ready), 32'd1);
    chk("full_head2_pc", out_pc, 32'h104);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("full_hold_pc", out_pc, 32'h104);
    chk("full_hold_src2", alu_src2, 32'h2000);
    out_ready = 1'b1;
    @(negedge clk);
    #1;
    chk("full_third_pc", out_pc, 32'h108);
    chk("full_third_src2", alu_src2, 32'h3000);
    chk("full_third_rd", 32'(out_rd), 32'd8);
    @(negedge clk);
    out_ready = 1'b0;
    #1 chk("full_empty", 32'(out_valid), 32'd0);

    // Flush with two entries, with a push and pop offered in the same cycle.
    push(32'h00001317, 32'h300);
    push(32'h00002397, 32'h304);
    flush = 1'b1; in_valid = 1'b1; in_inst = 32'h00003417; in_pc = 32'h308; out_ready = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_in_ready_after", 32'(in_ready), 32'd1);
    push(32'h00003417, 32'h30c);
    #1;
    chk("flush_refill_valid", 32'(out_valid), 32'd1);
    chk("flush_refill_pc", out_pc, 32'h30c);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Asynchronous reset mid-stream with two entries buffered.
    push(32'h12345117, 32'h80000000);
    push(32'h00001317, 32'h404);
    #2 rst = 1'b1;
    #1;
    chk("arst_out_valid", 32'(out_valid), 32'd0);
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_src1", alu_src1, 32'd0);
    chk("arst_src2", alu_src2, 32'd0);
    chk("arst_pc", out_pc, 32'd0);
    chk("arst_op_rd", {25'd0, alu_op, out_rd}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
